// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with accumulator and valid/ready handshake
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic [WIDTH-1:0] acc
);
    logic             accept;
    logic [WIDTH-1:0] r;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    always_comb begin
        case (op)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a | b);
            3'b100:  r = acc_q | a;
            3'b101:  r = acc_q & a;
            3'b110:  r = ACC_INIT;
            default: r = a;
        endcase
        out_valid_d = accept || (out_valid_q && !out_ready);
        result_d    = accept ? r : result_q;
        zero_d      = accept ? (r == '0) : zero_q;
        ones_d      = accept ? (&r) : ones_q;
        acc_d       = (accept && op[2] && op != 3'b111) ? r : acc_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            acc_q       <= acc_d;
        end
    end
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign acc       = acc_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: table-driven and scoreboard bench for logic_unit_pipe at WIDTH 32, 8 and 1
module tb_logic_unit_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid, zero, ones;
    logic [31:0] result, acc;

    logic        iv_s = 1'b0;
    logic [2:0]  op_s = '0;
    logic [7:0]  a8 = '0, b8 = '0, r8, acc8;
    logic        a1 = 1'b0, b1 = 1'b0, r1, acc1;
    logic        ir8, ov8, z8, o8, ir1, ov1, z1, o1;

    logic_unit_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ones(ones), .acc(acc));
    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h5A)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir8), .op(op_s),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(1'b1), .result(r8),
        .zero(z8), .ones(o8), .acc(acc8));
    logic_unit_pipe #(.WIDTH(1), .ACC_INIT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(ir1), .op(op_s),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(1'b1), .result(r1),
        .zero(z1), .ones(o1), .acc(acc1));

    typedef struct { logic [2:0] op; logic [31:0] a, b, e; } vec_t;
    typedef struct { logic [2:0] op; logic [7:0] a8, b8, e8; logic a1, b1, e1; } svec_t;

    vec_t tbl [12] = '{
        '{3'b001, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hBBBBBBBB},
        '{3'b001, 32'h00000001, 32'h00000000, 32'h00000001},
        '{3'b001, 32'h00000000, 32'h00000000, 32'h00000000},
        '{3'b000, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hAAAAAAAA},
        '{3'b010, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h11111111},
        '{3'b011, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h44444444},
        '{3'b011, 32'hABCABCAB, 32'hABCABCAB, 32'h54354354},
        '{3'b111, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF},
        '{3'b110, 32'h12345678, 32'h0000FFFF, 32'h00000000},
        '{3'b100, 32'h00000001, 32'h00000000, 32'h00000001},
        '{3'b100, 32'h80000000, 32'h00000000, 32'h80000001},
        '{3'b101, 32'h0000FFFF, 32'h00000000, 32'h00000001}
    };

    svec_t stbl [12] = '{
        '{3'b110, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1},
        '{3'b001, 8'hAA, 8'hBB, 8'hBB, 1'b0, 1'b1, 1'b1},
        '{3'b001, 8'h01, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0},
        '{3'b001, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1},
        '{3'b000, 8'hAA, 8'hBB, 8'hAA, 1'b1, 1'b0, 1'b0},
        '{3'b010, 8'hAA, 8'hBB, 8'h11, 1'b1, 1'b1, 1'b0},
        '{3'b011, 8'hAA, 8'hBB, 8'h44, 1'b0, 1'b0, 1'b1},
        '{3'b011, 8'hAB, 8'hAB, 8'h54, 1'b1, 1'b0, 1'b0},
        '{3'b111, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1},
        '{3'b101, 8'h0F, 8'h00, 8'h0A, 1'b0, 1'b0, 1'b0},
        '{3'b100, 8'h80, 8'h00, 8'h8A, 1'b1, 1'b0, 1'b1},
        '{3'b110, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1}
    };

    logic [2:0] rand_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

    int checks = 0, fails = 0, pushes = 0, pops = 0, drops = 0, sent = 0;
    logic [31:0] q [$];
    logic [31:0] exp_in = '0, m_hold = '0, m_acc = '0, exp_r;
    logic        m_valid = 1'b0, took = 1'b0, exp_ready, done = 1'b0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] e);
        checks++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", n, got, e, $time);
        end
    endtask

    function automatic logic [31:0] f(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x | y);
            default: return x;
        endcase
    endfunction

    // Scoreboard: check current outputs, then advance the model to what the next edge will do.
    always @(negedge clk) begin
        exp_ready = rst_n && (!m_valid || out_ready);
        exp_r = m_valid ? q[0] : m_hold;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("result", result, exp_r);
        chk("zero", {31'b0, zero}, {31'b0, exp_r == 32'h0});
        chk("ones", {31'b0, ones}, {31'b0, &exp_r});
        chk("acc", acc, m_acc);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        took = exp_ready && in_valid;
        if (!rst_n) begin
            drops += q.size();
            q.delete();
            m_valid = 1'b0;
            m_hold = '0;
            m_acc = '0;
        end else begin
            if (m_valid && out_ready) begin
                m_hold = q.pop_front();
                pops++;
            end
            if (took) begin
                q.push_back(exp_in);
                pushes++;
                if (op[2] && op != 3'b111) m_acc = exp_in;
            end
            m_valid = q.size() != 0;
        end
    end

    task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        int n = 0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        exp_in = e;
        sent++;
        do begin
            @(posedge clk);
            n++;
        end while (!took && n < 200);
        #1;
        if (!took) begin
            checks++;
            fails++;
            $display("FAIL send_timeout op=%0d got=no_accept exp=accept", o);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid = 1'b1;
        iv_s = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("w8_rst_valid", {31'b0, ov8}, 32'h0);
        chk("w8_rst_result", {24'b0, r8}, 32'h0);
        chk("w8_rst_zero", {31'b0, z8}, 32'h1);
        chk("w8_rst_acc", {24'b0, acc8}, 32'h5A);
        chk("w8_rst_ready", {31'b0, ir8}, 32'h0);
        chk("w1_rst_zero", {31'b0, z1}, 32'h1);
        chk("w1_rst_ones", {31'b0, o1}, 32'h0);
        chk("w1_rst_acc", {31'b0, acc1}, 32'h1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        iv_s = 1'b0;
        @(posedge clk);
        #1;
        foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
        idle(2);

        out_ready = 1'b0;
        fork
            begin
                send(3'b001, 32'h1, 32'h2, 32'h3);
                send(3'b100, 32'h10, 32'h0, 32'h11);
                idle(1);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(2);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [2:0] o;
                    logic [31:0] x, y;
                    o = rand_ops[$urandom_range(0, 4)];
                    x = $urandom;
                    y = $urandom;
                    send(o, x, y, f(o, x, y));
                end
                idle(1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        idle(3);

        send(3'b110, 32'h0, 32'h0, 32'h0);
        send(3'b100, 32'h1, 32'h0, 32'h1);
        send(3'b100, 32'h2, 32'h0, 32'h3);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(3'b100, 32'h4, 32'h0, 32'h4);
        send(3'b100, 32'h8, 32'h0, 32'hC);
        idle(3);

        foreach (stbl[i]) begin
            op_s = stbl[i].op;
            a8 = stbl[i].a8;
            b8 = stbl[i].b8;
            a1 = stbl[i].a1;
            b1 = stbl[i].b1;
            iv_s = 1'b1;
            @(posedge clk);
            #1;
            chk("w8_valid", {31'b0, ov8}, 32'h1);
            chk("w8_result", {24'b0, r8}, {24'b0, stbl[i].e8});
            chk("w8_zero", {31'b0, z8}, {31'b0, stbl[i].e8 == 8'h0});
            chk("w8_ones", {31'b0, o8}, {31'b0, stbl[i].e8 == 8'hFF});
            chk("w1_valid", {31'b0, ov1}, 32'h1);
            chk("w1_result", {31'b0, r1}, {31'b0, stbl[i].e1});
            chk("w1_zero", {31'b0, z1}, {31'b0, !stbl[i].e1});
            chk("w1_ones", {31'b0, o1}, {31'b0, stbl[i].e1});
        end
        iv_s = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_drain", {31'b0, ov8}, 32'h0);
        chk("w8_acc_end", {24'b0, acc8}, 32'h5A);
        chk("w1_acc_end", {31'b0, acc1}, 32'h1);

        chk("sb_accepted", pushes, sent);
        chk("sb_drained", pops + drops, pushes);
        chk("sb_dropped", drops, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
